// File: rtl/rtc_alarm_clock_if.sv
// Control/status bundle between the RTC core and the system/display side.
interface rtc_alarm_clock_if;
  logic        en;
  logic        load_time;
  logic [23:0] time_in;
  logic        alarm_set;
  logic [15:0] alarm_in;
  logic        alarm_en;
  logic        alarm_ack;
  logic        snooze;
  logic        mode_12h;
  logic [23:0] time_out;
  logic        pm;
  logic        sec_pulse;
  logic        alarm_ring;
  logic        load_err;

  modport master (
    output en, load_time, time_in, alarm_set, alarm_in, alarm_en, alarm_ack, snooze, mode_12h,
    input  time_out, pm, sec_pulse, alarm_ring, load_err
  );
  modport slave (
    input  en, load_time, time_in, alarm_set, alarm_in, alarm_en, alarm_ack, snooze, mode_12h,
    output time_out, pm, sec_pulse, alarm_ring, load_err
  );
endinterface

// File: rtl/rtc_alarm_clock.sv
// BCD hh:mm:ss clock with prescaler, validated loads, 12/24h display and
// an alarm with ring timeout and snooze. Time is always held as 24h BCD.
module rtc_alarm_clock #(
  parameter int TICK_DIV   = 50000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic           clk,
  input  logic           rst_n,
  rtc_alarm_clock_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre;
  logic [23:0]   tm, tm_inc;
  logic [15:0]   alarm;
  logic [7:0]    ring_cnt, ring_n;
  logic [15:0]   snz_cnt, snz_n;
  logic          sec_pulse, load_err;
  logic          tick, adv, match, time_ok, alarm_ok;
  logic [4:0]    hb, h12;

  function automatic logic ok_hm(logic [7:0] h, logic [7:0] m);
    return (h[7:4] <= 4'd2) && (h[3:0] <= 4'd9) && !(h[7:4] == 4'd2 && h[3:0] > 4'd3) &&
           (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9);
  endfunction

  function automatic logic [23:0] inc_time(logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       c;
    {h1, h0, m1, m0, s1, s0} = t;
    c = 1'b0;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin s1 = 4'd0; c = 1'b1; end
    end
    if (c) begin
      c = 1'b0;
      if (m0 != 4'd9) m0 = m0 + 4'd1;
      else begin
        m0 = 4'd0;
        if (m1 != 4'd5) m1 = m1 + 4'd1;
        else begin m1 = 4'd0; c = 1'b1; end
      end
    end
    if (c) begin
      if ({h1, h0} == 8'h23) {h1, h0} = 8'h00;
      else if (h0 == 4'd9) begin h0 = 4'd0; h1 = h1 + 4'd1; end
      else h0 = h0 + 4'd1;
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  assign tick     = bus.en && (pre == PW'(TICK_DIV - 1));
  assign adv      = tick && !bus.load_time;
  assign tm_inc   = inc_time(tm);
  assign time_ok  = ok_hm(bus.time_in[23:16], bus.time_in[15:8]) &&
                    (bus.time_in[7:4] <= 4'd5) && (bus.time_in[3:0] <= 4'd9);
  assign alarm_ok = ok_hm(bus.alarm_in[15:8], bus.alarm_in[7:0]);
  // Compared against the stored alarm, so a same-cycle alarm_set does not count.
  assign match    = adv && (tm_inc[7:0] == 8'h00) && (tm_inc[23:8] == alarm);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre       <= '0;
      tm        <= '0;
      alarm     <= '0;
      sec_pulse <= 1'b0;
      load_err  <= 1'b0;
      state     <= IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
    end else begin
      // Any load_time, valid or not, freezes the prescaler for that cycle.
      if (bus.load_time) begin
        if (time_ok) begin
          tm  <= bus.time_in;
          pre <= '0;
        end
      end else if (bus.en) begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) tm <= tm_inc;
      end
      if (bus.alarm_set && alarm_ok) alarm <= bus.alarm_in;
      sec_pulse <= adv;
      load_err  <= (bus.load_time && !time_ok) || (bus.alarm_set && !alarm_ok);
      state     <= state_n;
      ring_cnt  <= ring_n;
      snz_cnt   <= snz_n;
    end
  end

  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    snz_n   = snz_cnt;
    if (!bus.alarm_en) state_n = IDLE;
    else begin
      case (state)
        IDLE: if (match) begin state_n = RING; ring_n = '0; end
        RING: begin
          if (bus.alarm_ack) state_n = IDLE;
          else if (bus.snooze) begin state_n = SNOOZE; snz_n = '0; end
          else if (adv) begin
            if (ring_cnt == 8'(RING_SEC - 1)) state_n = IDLE;
            else ring_n = ring_cnt + 8'd1;
          end
        end
        SNOOZE: begin
          if (bus.alarm_ack) state_n = IDLE;
          else if (adv) begin
            if (snz_cnt == 16'(SNOOZE_SEC - 1)) begin state_n = RING; ring_n = '0; end
            else snz_n = snz_cnt + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // 12h view: convert hours to binary, remap, and back to two BCD digits.
  always_comb begin
    hb  = 5'(tm[23:20]) * 5'd10 + 5'(tm[19:16]);
    h12 = (hb == 5'd0) ? 5'd12 : (hb > 5'd12) ? hb - 5'd12 : hb;
  end

  assign bus.time_out   = bus.mode_12h ?
                          {(h12 >= 5'd10) ? 4'd1 : 4'd0,
                           (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12), tm[15:0]} : tm;
  assign bus.pm         = (tm[23:16] >= 8'h12);
  assign bus.sec_pulse  = sec_pulse;
  assign bus.alarm_ring = (state == RING);
  assign bus.load_err   = load_err;
endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Directed bench for rtc_alarm_clock: load table plus hand-written tick/alarm sequences.
module tb_rtc_alarm_clock;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rtc_alarm_clock_if bus();

  rtc_alarm_clock #(.TICK_DIV(4), .RING_SEC(3), .SNOOZE_SEC(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] ti;
    logic        mode;
    logic [23:0] out;
    logic        pm;
    logic        err;
  } vec_t;
  vec_t tbl[10];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for the next sec_pulse and checks how many cycles it took.
  task automatic wait_tick(input string nm, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (bus.sec_pulse) begin n = i; break; end
    end
    chk({nm, "_interval"}, 32'(n), 32'(exp_n));
  endtask

  task automatic load(input logic [23:0] t);
    bus.load_time = 1'b1;
    bus.time_in   = t;
    cyc();
    bus.load_time = 1'b0;
  endtask

  task automatic aset(input logic [15:0] a, input logic exp_err);
    bus.alarm_set = 1'b1;
    bus.alarm_in  = a;
    cyc();
    bus.alarm_set = 1'b0;
    chk("alarm_set_err", 32'(bus.load_err), 32'(exp_err));
  endtask

  function automatic logic [7:0] bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  initial begin
    tbl[0] = '{24'h235958, 1'b0, 24'h235958, 1'b1, 1'b0};
    tbl[1] = '{24'h130000, 1'b1, 24'h010000, 1'b1, 1'b0};
    tbl[2] = '{24'h000000, 1'b1, 24'h120000, 1'b0, 1'b0};
    tbl[3] = '{24'h246000, 1'b1, 24'h120000, 1'b0, 1'b1};
    tbl[4] = '{24'h125A00, 1'b0, 24'h000000, 1'b0, 1'b1};
    tbl[5] = '{24'h120000, 1'b1, 24'h120000, 1'b1, 1'b0};
    tbl[6] = '{24'h235959, 1'b1, 24'h115959, 1'b1, 1'b0};
    tbl[7] = '{24'h200000, 1'b1, 24'h080000, 1'b1, 1'b0};
    tbl[8] = '{24'h095960, 1'b0, 24'h200000, 1'b1, 1'b1};
    tbl[9] = '{24'h110000, 1'b1, 24'h110000, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.en = 1'b1; bus.load_time = 1'b0; bus.time_in = '0;
    bus.alarm_set = 1'b0; bus.alarm_in = '0; bus.alarm_en = 1'b0;
    bus.alarm_ack = 1'b0; bus.snooze = 1'b0; bus.mode_12h = 1'b1;

    // Reset state
    cyc(); cyc();
    chk("rst_time_12h", 32'(bus.time_out), 32'h120000);
    bus.mode_12h = 1'b0; #1;
    chk("rst_time_24h", 32'(bus.time_out), 32'h000000);
    chk("rst_pm", 32'(bus.pm), 0);
    chk("rst_pulse", 32'(bus.sec_pulse), 0);
    chk("rst_ring", 32'(bus.alarm_ring), 0);
    chk("rst_err", 32'(bus.load_err), 0);

    // Free run for one minute
    rst_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      wait_tick("run", 4);
      chk("run_time", 32'(bus.time_out), {8'h00, 8'h00, bcd(k / 60), bcd(k % 60)});
    end

    // Load table with the clock stopped
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.mode_12h = tbl[i].mode;
      load(tbl[i].ti);
      chk($sformatf("tbl%0d_time", i), 32'(bus.time_out), 32'(tbl[i].out));
      chk($sformatf("tbl%0d_pm", i), 32'(bus.pm), 32'(tbl[i].pm));
      chk($sformatf("tbl%0d_err", i), 32'(bus.load_err), 32'(tbl[i].err));
    end
    cyc();
    chk("err_one_cycle", 32'(bus.load_err), 0);
    bus.mode_12h = 1'b0;

    // Alarm validation: valid 00:01 kept despite two rejected sets
    aset(16'h0001, 1'b0);
    aset(16'h2400, 1'b1);
    aset(16'h125A, 1'b1);

    // Midnight rollover
    bus.en = 1'b1;
    load(24'h235958);
    wait_tick("roll1", 4);
    chk("roll1_time", 32'(bus.time_out), 32'h235959);
    wait_tick("roll2", 4);
    chk("roll2_time", 32'(bus.time_out), 32'h000000);
    bus.mode_12h = 1'b1; #1;
    chk("roll2_12h", 32'(bus.time_out), 32'h120000);
    chk("roll2_pm", 32'(bus.pm), 0);
    bus.mode_12h = 1'b0;
    wait_tick("roll3", 4);
    chk("roll3_time", 32'(bus.time_out), 32'h000001);

    // Load coinciding with a tick
    cyc(); cyc(); cyc();
    load(24'h101010);
    chk("loadtick_pulse", 32'(bus.sec_pulse), 0);
    chk("loadtick_time", 32'(bus.time_out), 32'h101010);
    wait_tick("loadtick_next", 4);
    chk("loadtick_next_time", 32'(bus.time_out), 32'h101011);

    // Alarm ring and timeout
    bus.alarm_en = 1'b1;
    load(24'h000058);
    wait_tick("al1", 4);
    chk("al1_ring", 32'(bus.alarm_ring), 0);
    wait_tick("al2", 4);
    chk("al2_time", 32'(bus.time_out), 32'h000100);
    chk("al2_ring", 32'(bus.alarm_ring), 1);
    wait_tick("al3", 4);
    chk("al3_ring", 32'(bus.alarm_ring), 1);
    wait_tick("al4", 4);
    chk("al4_ring", 32'(bus.alarm_ring), 1);
    wait_tick("al5", 4);
    chk("al5_ring_timeout", 32'(bus.alarm_ring), 0);

    // Disarmed alarm does not ring
    bus.alarm_en = 1'b0;
    load(24'h000058);
    wait_tick("dis1", 4);
    wait_tick("dis2", 4);
    chk("dis_time", 32'(bus.time_out), 32'h000100);
    chk("dis_ring", 32'(bus.alarm_ring), 0);

    // Snooze then re-ring
    bus.alarm_en = 1'b1;
    load(24'h000059);
    wait_tick("sn0", 4);
    chk("sn0_ring", 32'(bus.alarm_ring), 1);
    bus.snooze = 1'b1;
    cyc();
    bus.snooze = 1'b0;
    chk("sn_ring_low", 32'(bus.alarm_ring), 0);
    wait_tick("sn1", 3);
    chk("sn1_ring", 32'(bus.alarm_ring), 0);
    wait_tick("sn2", 4);
    chk("sn2_rering", 32'(bus.alarm_ring), 1);

    // Ack wins over snooze
    bus.alarm_ack = 1'b1; bus.snooze = 1'b1;
    cyc();
    bus.alarm_ack = 1'b0; bus.snooze = 1'b0;
    chk("ack_ring", 32'(bus.alarm_ring), 0);
    wait_tick("ack1", 3);
    wait_tick("ack2", 4);
    wait_tick("ack3", 4);
    chk("ack_no_rering", 32'(bus.alarm_ring), 0);

    // en=0 holds ring and time, reset clears it
    load(24'h000059);
    wait_tick("hold", 4);
    chk("hold_ring0", 32'(bus.alarm_ring), 1);
    bus.en = 1'b0;
    repeat (20) cyc();
    chk("hold_ring", 32'(bus.alarm_ring), 1);
    chk("hold_time", 32'(bus.time_out), 32'h000100);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_ring_mid", 32'(bus.alarm_ring), 0);
    chk("rst_time_mid", 32'(bus.time_out), 32'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
